// File: rtl/frame_transfer_pkg.sv
// Shared constants for the frame transfer stage: state encoding, packet
// header magic, the sync-FSM transfer state code and a packet-size helper.
package frame_transfer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HDR0      = 3'd1;
  localparam logic [2:0] ST_HDR1      = 3'd2;
  localparam logic [2:0] ST_PIXELS    = 3'd3;
  localparam logic [2:0] ST_TRAILER   = 3'd4;
  localparam logic [2:0] ST_DONE_WAIT = 3'd5;

  localparam logic [15:0] HDR_MAGIC   = 16'hA55A;

  // State code the sync FSM drives while it wants a frame moved to the host.
  localparam logic [1:0]  SM_TRANSFER = 2'd2;

  // Words per completed packet: two header words, the pixels, one checksum.
  function automatic int frame_words(input int cols, input int rows);
    return cols * rows + 3;
  endfunction

endpackage

// File: rtl/frame_transfer.sv
// Frame transfer stage: on a transfer request from the sync FSM, packs one
// sensor frame as {magic, tag, pixels..., checksum} into the 16-bit USB FIFO
// and reports completion with DONE.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | waiting for iSTATE==transfer with the host file open
// ST_HDR0      | write HDR_MAGIC when the FIFO has room
// ST_HDR1      | write {8'h00, latched tag} when the FIFO has room
// ST_PIXELS    | accept pixels, write each one, accumulate checksum
// ST_TRAILER   | write the 16-bit checksum when the FIFO has room
// ST_DONE_WAIT | hold DONE until the sync FSM leaves the transfer state
module frame_transfer #(
  parameter int          COLS      = 640,
  parameter int          ROWS      = 480,
  parameter int          CNT_W     = 19,
  parameter logic [15:0] HDR_MAGIC = frame_transfer_pkg::HDR_MAGIC
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [1:0]  iSTATE,
  input  logic        iFILE_OPEN,
  input  logic [7:0]  iTAG,
  input  logic [9:0]  iPIX,
  input  logic        iPIX_VALID,
  output logic        oPIX_READY,
  output logic [15:0] oDATA,
  output logic        oWR,
  input  logic        iFULL,
  output logic        DONE,
  output logic        oBUSY
);

  import frame_transfer_pkg::*;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(COLS * ROWS - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] pix_cnt;
  logic [15:0]      checksum;
  logic [7:0]       tag_q;
  logic             accept;

  // Pixel handshake: ready only while streaming pixels and the FIFO has room.
  always_comb begin
    oPIX_READY = (state == ST_PIXELS) && !iFULL;
    accept     = oPIX_READY && iPIX_VALID;
    oBUSY      = (state != ST_IDLE);
  end

  // Packet sequencer: registered FIFO writes, checksum, tag latch and DONE.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      oWR      <= 1'b0;
      oDATA    <= 16'h0000;
      DONE     <= 1'b0;
      pix_cnt  <= '0;
      checksum <= 16'h0000;
      tag_q    <= 8'h00;
    end else begin
      oWR <= 1'b0;
      if (!iFILE_OPEN) begin
        // Host closed the file: drop the partial packet, no trailer.
        state <= ST_IDLE;
        DONE  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            DONE <= 1'b0;
            if (iSTATE == SM_TRANSFER) begin
              tag_q    <= iTAG;
              pix_cnt  <= '0;
              checksum <= 16'h0000;
              state    <= ST_HDR0;
            end
          end
          ST_HDR0: begin
            if (!iFULL) begin
              oDATA <= HDR_MAGIC;
              oWR   <= 1'b1;
              state <= ST_HDR1;
            end
          end
          ST_HDR1: begin
            if (!iFULL) begin
              oDATA <= {8'h00, tag_q};
              oWR   <= 1'b1;
              state <= ST_PIXELS;
            end
          end
          ST_PIXELS: begin
            if (accept) begin
              oDATA    <= {6'b0, iPIX};
              oWR      <= 1'b1;
              checksum <= checksum + {6'b0, iPIX};
              pix_cnt  <= pix_cnt + CNT_W'(1);
              if (pix_cnt == LAST_PIX) begin
                state <= ST_TRAILER;
              end
            end
          end
          ST_TRAILER: begin
            if (!iFULL) begin
              oDATA <= checksum;
              oWR   <= 1'b1;
              DONE  <= 1'b1;
              state <= ST_DONE_WAIT;
            end
          end
          ST_DONE_WAIT: begin
            // The sync FSM updates on negedge; keep DONE up until it moves on.
            if (iSTATE != SM_TRANSFER) begin
              DONE  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: begin
            DONE  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_transfer.sv
// Directed bench for frame_transfer: a 4x2 instance for protocol checks and
// a 64x2 instance for 16-bit checksum wrap.
module tb_frame_transfer;
  import frame_transfer_pkg::*;

  logic        CLOCK;
  logic        RESET;
  logic        fo;

  logic [1:0]  st_a;
  logic [7:0]  tag_a;
  logic [9:0]  pix_a;
  logic        pv_a, full_a;
  logic        ready_a, wr_a, done_a, busy_a;
  logic [15:0] data_a;

  logic [1:0]  st_b;
  logic [7:0]  tag_b;
  logic [9:0]  pix_b;
  logic        pv_b, full_b;
  logic        ready_b, wr_b, done_b, busy_b;
  logic [15:0] data_b;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] q_a[$];
  int          nb_wr = 0;
  logic [15:0] last_b = 16'h0;
  logic [9:0]  pix_arr[8];

  frame_transfer #(.COLS(4), .ROWS(2)) dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .iSTATE(st_a), .iFILE_OPEN(fo),
    .iTAG(tag_a), .iPIX(pix_a), .iPIX_VALID(pv_a), .oPIX_READY(ready_a),
    .oDATA(data_a), .oWR(wr_a), .iFULL(full_a), .DONE(done_a), .oBUSY(busy_a)
  );

  frame_transfer #(.COLS(64), .ROWS(2), .CNT_W(8)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .iSTATE(st_b), .iFILE_OPEN(fo),
    .iTAG(tag_b), .iPIX(pix_b), .iPIX_VALID(pv_b), .oPIX_READY(ready_b),
    .oDATA(data_b), .oWR(wr_b), .iFULL(full_b), .DONE(done_b), .oBUSY(busy_b)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  always @(negedge CLOCK) begin
    if (wr_a) q_a.push_back(data_a);
    if (wr_b) begin
      nb_wr  = nb_wr + 1;
      last_b = data_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Run one frame on dut_a; optional FIFO stall of stall_len cycles once
  // stall_at pixels have been accepted. Returns once DONE is seen.
  task automatic run_a(input logic [7:0] tag, input int stall_at, input int stall_len);
    int  idx  = 0;
    int  scnt = 0;
    bit  seen = 0;
    q_a.delete();
    @(negedge CLOCK);
    st_a  = SM_TRANSFER;
    tag_a = tag;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge CLOCK);
      if (c == 4) tag_a = ~tag;
      full_a = (idx == stall_at && scnt < stall_len);
      pv_a   = (idx < 8);
      pix_a  = (idx < 8) ? pix_arr[idx] : 10'd0;
      #1;
      if (full_a) begin
        check("stall_ready", ready_a, 1'b0);
        if (scnt > 0) check("stall_wr", wr_a, 1'b0);
        scnt++;
      end
      if (pv_a && ready_a) idx++;
      if (done_a) seen = 1;
    end
    full_a = 1'b0;
    pv_a   = 1'b0;
    check("done_seen", seen, 1'b1);
  endtask

  task automatic verify_a(input logic [7:0] tag, input logic [15:0] trailer);
    logic [15:0] sum = 16'h0;
    check("word_count", q_a.size(), frame_words(4, 2));
    if (q_a.size() == frame_words(4, 2)) begin
      check("hdr0", q_a[0], 16'hA55A);
      check("hdr1", q_a[1], {8'h00, tag});
      for (int i = 0; i < 8; i++) begin
        check("pixel", q_a[2 + i], {6'b0, pix_arr[i]});
        sum = sum + {6'b0, pix_arr[i]};
      end
      check("trailer_model", q_a[10], sum);
      check("trailer_hand", q_a[10], trailer);
    end
  endtask

  // Keep iSTATE at transfer for n cycles after DONE, then release it.
  task automatic hold_a(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLOCK); #1;
      check("done_hold", done_a, 1'b1);
      check("hold_no_wr", wr_a, 1'b0);
    end
    @(negedge CLOCK);
    st_a = 2'd0;
    @(negedge CLOCK); #1;
    check("done_release", done_a, 1'b0);
    check("idle_busy", busy_a, 1'b0);
    check("no_restart_words", q_a.size(), frame_words(4, 2));
  endtask

  initial begin
    int idx;
    RESET = 1'b1; fo = 1'b1;
    st_a = 2'd0; tag_a = 8'h00; pix_a = 10'd0; pv_a = 1'b0; full_a = 1'b0;
    st_b = 2'd0; tag_b = 8'h00; pix_b = 10'd0; pv_b = 1'b0; full_b = 1'b0;
    #1;
    check("rst_wr", wr_a, 1'b0);
    check("rst_data", data_a, 16'h0000);
    check("rst_done", done_a, 1'b0);
    check("rst_ready", ready_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    @(negedge CLOCK); @(negedge CLOCK);
    RESET = 1'b0;

    // Basic frame, tag 07, pixels 1..8, DONE held six cycles.
    for (int i = 0; i < 8; i++) pix_arr[i] = 10'(i + 1);
    run_a(8'h07, -1, 0);
    verify_a(8'h07, 16'h0024);
    hold_a(6);

    // Same frame with a five-cycle FIFO stall mid-pixels.
    run_a(8'h07, 3, 5);
    verify_a(8'h07, 16'h0024);
    hold_a(1);

    // All-ones pixels.
    for (int i = 0; i < 8; i++) pix_arr[i] = 10'h3FF;
    run_a(8'h5C, -1, 0);
    verify_a(8'h5C, 16'h1FF8);
    hold_a(1);

    // Abort after three pixels.
    for (int i = 0; i < 8; i++) pix_arr[i] = 10'(i + 1);
    q_a.delete();
    @(negedge CLOCK);
    st_a = SM_TRANSFER; tag_a = 8'h21; idx = 0;
    for (int c = 0; c < 50 && idx < 3; c++) begin
      @(negedge CLOCK);
      pix_a = pix_arr[idx]; pv_a = 1'b1;
      #1;
      if (pv_a && ready_a) idx++;
    end
    check("abort_reach", idx, 3);
    @(negedge CLOCK);
    fo = 1'b0; pv_a = 1'b0;
    @(negedge CLOCK); #1;
    check("abort_busy", busy_a, 1'b0);
    check("abort_wr", wr_a, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK); #1;
      check("abort_done", done_a, 1'b0);
    end
    check("abort_words", q_a.size(), 5);
    if (q_a.size() == 5) check("abort_last", q_a[4], 16'h0003);
    st_a = 2'd0;
    @(negedge CLOCK);
    fo = 1'b1;
    run_a(8'h22, -1, 0);
    verify_a(8'h22, 16'h0024);
    hold_a(1);

    // Asynchronous reset in the middle of the pixel phase.
    @(negedge CLOCK);
    st_a = SM_TRANSFER; tag_a = 8'h33; idx = 0;
    for (int c = 0; c < 50 && idx < 2; c++) begin
      @(negedge CLOCK);
      pix_a = pix_arr[idx]; pv_a = 1'b1;
      #1;
      if (pv_a && ready_a) idx++;
    end
    @(posedge CLOCK); #2;
    check("pre_reset_wr", wr_a, 1'b1);
    RESET = 1'b1;
    #1;
    check("async_wr", wr_a, 1'b0);
    check("async_data", data_a, 16'h0000);
    check("async_done", done_a, 1'b0);
    check("async_ready", ready_a, 1'b0);
    check("async_busy", busy_a, 1'b0);
    @(negedge CLOCK);
    st_a = 2'd0; pv_a = 1'b0;
    RESET = 1'b0;

    // 64x2 instance: 128 * 0x3FF wraps to 0xFF80.
    nb_wr = 0;
    @(negedge CLOCK);
    st_b = SM_TRANSFER; tag_b = 8'h01; pix_b = 10'h3FF; pv_b = 1'b1;
    for (int c = 0; c < 400 && !done_b; c++) begin
      @(negedge CLOCK); #1;
    end
    check("b_done", done_b, 1'b1);
    check("b_words", nb_wr, frame_words(64, 2));
    check("b_trailer", last_b, 16'hFF80);
    st_b = 2'd0; pv_b = 1'b0;
    @(negedge CLOCK); @(negedge CLOCK); #1;
    check("b_release", done_b, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frame_transfer.md
Name: frame_transfer

Overview:
- Downstream stage of the frame-sync state machine.
- When that FSM reports state 2 (transfer), this block does the following:
  - reads one frame of pixels from the sensor pixel stream;
  - frames it as a header, the pixels and a checksum trailer;
  - writes that packet word by word into the 16-bit host USB FIFO;
  - asserts DONE so the sync FSM advances its frame counter.
- It sits between the sensor capture path and the USB FIFO writer.

Parameters:
- COLS, 640: pixels per row.
- ROWS, 480: rows per frame.
- CNT_W, 19: pixel counter width; must satisfy 2^CNT_W >= COLS*ROWS.
- HDR_MAGIC, 16'hA55A: first header word of every frame packet.

Ports:
- CLOCK  in  1  system clock; all logic is on posedge.
- RESET  in  1  asynchronous, active-high reset.
- iSTATE  in  2  state from the sync FSM (changes on negedge); value 2 = transfer requested.
- iFILE_OPEN  in  1  host file open; low aborts any transfer.
- iTAG  in  8  frame tag (the sync FSM's look_for counter), latched at start.
- iPIX  in  10  sensor pixel.
- iPIX_VALID  in  1  iPIX is valid this cycle.
- oPIX_READY  out  1  pixel accepted when iPIX_VALID && oPIX_READY.
- oDATA  out  16  USB FIFO write data.
- oWR  out  1  USB FIFO write strobe, one word per high cycle.
- iFULL  in  1  USB FIFO full; almost-full semantics, so the FIFO tolerates one write in the cycle iFULL rises.
- DONE  out  1  transfer complete, to the sync FSM.
- oBUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE, oWR=0, oDATA=0, DONE=0, oPIX_READY=0, oBUSY=0, pixel counter=0, checksum=0, latched tag=0.
- States: IDLE, HDR0, HDR1, PIXELS, TRAILER, DONE_WAIT (constants in the package).
- IDLE:
  - if iSTATE==2 and iFILE_OPEN=1 at posedge: latch iTAG, clear counter and checksum, go to HDR0.
  - otherwise stay.
- HDR0: when iFULL=0, register oDATA=HDR_MAGIC and oWR=1 for one cycle, go to HDR1. If iFULL=1, stall with oWR=0.
- HDR1: when iFULL=0, write {8'h00, tag}, go to PIXELS.
- PIXELS:
  - oPIX_READY = (state==PIXELS) && !iFULL (combinational).
  - On each accept, the next cycle shows oDATA={6'b0, iPIX} and oWR=1.
  - Each accept also does checksum <= checksum + {6'b0, iPIX} (mod 2^16) and counter+1.
  - On the accept where counter==COLS*ROWS-1, go to TRAILER.
  - No write occurs in cycles without an accept.
- TRAILER: when iFULL=0, write the final checksum, go to DONE_WAIT.
- DONE_WAIT:
  - DONE=1 (registered); hold it until iSTATE!=2 is sampled, then DONE=0 and go to IDLE.
  - This guarantees the sync FSM samples DONE regardless of its negedge state update.
- Write latency: oWR/oDATA are registered, one cycle after the decision edge. oWR is never high two cycles beyond a cycle where iFULL was sampled high.
- Abort:
  - iFILE_OPEN=0 in any state forces the next state to IDLE, DONE=0, oWR=0 on the next edge.
  - The partial packet is not completed and no trailer is sent.
- A new transfer requires a return to IDLE; iSTATE==2 seen in DONE_WAIT does not restart.
- iTAG changes after the latch have no effect on the current packet.
- Simultaneous accept and iFULL rising: the accepted pixel is still written (almost-full semantics).
- Exactly COLS*ROWS+3 words are written per completed frame.

Decomposition:
- Package frame_transfer_pkg holds:
  - the state encoding constants;
  - HDR_MAGIC;
  - the FRAME_WORDS = COLS*ROWS + 3 helper;
  - the SM_TRANSFER = 2'd2 constant shared with the sync FSM.
- No sub-module is needed; the checksum accumulator is inline.
- Verification is done with small COLS/ROWS values.

Test Plan (COLS=4, ROWS=2):
- Basic frame:
  - Stimulus: iTAG=8'h07, iSTATE=2, pixels 1..8 with continuous valid, iFULL=0.
  - Response: words A55A, 0007, 0001..0008, 0024; then DONE=1 until iSTATE returns to 0; exactly 11 oWR pulses.
- Back-pressure: the basic frame with iFULL=1 for 5 cycles mid-pixels. Response: no oWR and oPIX_READY=0 during the stall, and identical output words.
- Checksum wrap: all pixels 10'h3FF. Response: trailer = 8*0x03FF = 0x1FF8. Also a case with COLS=64, ROWS=2 and 128*0x3FF, checking 16-bit wrap = 0xFF80.
- Abort: iFILE_OPEN=0 after 3 pixels. Response: IDLE within one cycle, no trailer, DONE never asserted. A subsequent frame restarts with header A55A.
- Reset mid-PIXELS: assert RESET asynchronously. Response: all outputs 0 immediately without waiting for a clock edge, oBUSY=0.
- DONE hold: iSTATE stays 2 for 6 cycles after the trailer. Response: DONE held high 6 cycles, no second header emitted.
